// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: load/store unit between the core MEM stage and a 1R/1W data memory.
// Accepts one byte-addressed load or store at a time over valid/ready and returns
// extended load data or a store acknowledge. Sub-word stores are done as a
// read-modify-write. Misaligned accesses and illegal funct3 codes return resp_err.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req_*             request channel: valid/ready, we, funct3, byte addr, wdata
//   resp_*            response channel: valid/ready, extended rdata, err
//   mem_rd_addr       memory read address (combinational read returns mem_rd_dout)
//   mem_wr_addr/_din  memory write address/data, committed on edges with mem_we=1
module lsu_dmem_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [XLEN-1:0]   mem_wr_din,
    output logic              mem_we,
    input  logic [XLEN-1:0]   mem_rd_dout
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned SHW    = 5;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_t;

    state_t              state;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;

    logic [SHW-1:0]      lane_sh;
    logic [XLEN-1:0]     lane_data;
    logic [BYTE_W-1:0]   lane_byte;
    logic [HALF_W-1:0]   lane_half;
    logic [XLEN-1:0]     load_data;
    logic [XLEN-1:0]     lane_mask;
    logic [XLEN-1:0]     merged;

    // Legality of an incoming request: unknown width codes and misaligned H/W.
    function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        if (we) begin
            bad = (f3 > F3_W);
        end else begin
            bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            bad = bad | a[0];
        end
        if (f3 == F3_W) begin
            bad = bad | (a != 2'b00);
        end
        return bad;
    endfunction

    // Memory addresses come only from the latched request address.
    assign mem_rd_addr = addr_q;
    assign mem_wr_addr = addr_q;

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        lane_sh   = {addr_q[1:0], 3'b000};
        lane_data = mem_rd_dout >> lane_sh;
        lane_byte = lane_data[BYTE_W-1:0];
        lane_half = lane_data[HALF_W-1:0];
        load_data = '0;
        case (funct3_q)
            F3_B:    load_data = {{(XLEN-BYTE_W){lane_byte[BYTE_W-1]}}, lane_byte};
            F3_H:    load_data = {{(XLEN-HALF_W){lane_half[HALF_W-1]}}, lane_half};
            F3_W:    load_data = mem_rd_dout;
            F3_BU:   load_data = {{(XLEN-BYTE_W){1'b0}}, lane_byte};
            F3_HU:   load_data = {{(XLEN-HALF_W){1'b0}}, lane_half};
            default: load_data = '0;
        endcase
        if (funct3_q == F3_B) begin
            lane_mask = XLEN'({BYTE_W{1'b1}}) << lane_sh;
        end else begin
            lane_mask = XLEN'({HALF_W{1'b1}}) << lane_sh;
        end
        merged = (mem_rd_dout & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    end

    // Control FSM; every output and memory strobe is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_wr_din <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_we <= 1'b0;
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (is_illegal(req_we, req_funct3, req_addr[1:0])) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= S_ACCESS;
                            // Full-word store writes during the ACCESS cycle itself.
                            if (req_we && (req_funct3 == F3_W)) begin
                                mem_we     <= 1'b1;
                                mem_wr_din <= req_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                    end else if (funct3_q == F3_W) begin
                        state      <= S_RESP;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        // Sub-word store: merged word is written in WRITE.
                        state      <= S_WRITE;
                        mem_we     <= 1'b1;
                        mem_wr_din <= merged;
                    end
                end
                S_WRITE: begin
                    state      <= S_RESP;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                S_RESP: begin
                    mem_we <= 1'b0;
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl with a behavioural 1R/1W word memory.
module tb_lsu_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  mem_rd_addr;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_din;
    logic        mem_we;
    logic [31:0] mem_rd_dout;

    lsu_dmem_ctrl #(.ADDR_W(8), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
        .mem_wr_din(mem_wr_din), .mem_we(mem_we), .mem_rd_dout(mem_rd_dout)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write on rising edge; preloaded on first edge.
    logic [31:0] mem [0:63];
    logic        mem_init = 1'b0;
    assign mem_rd_dout = mem[mem_rd_addr[7:2]];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
            mem[1]   <= 32'h8899AABB;
            mem[3]   <= 32'h11223344;
            mem_init <= 1'b1;
        end else if (mem_we) begin
            mem[mem_wr_addr[7:2]] <= mem_wr_din;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we_cnt;
        int          we_lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t q[$];

    // Monitor: checks responses, hold stability, req_ready during RESP, write strobes.
    logic        in_resp = 1'b0;
    int          first_cyc;
    logic [31:0] hold_rdata;
    logic        hold_err;
    int          we_cnt = 0;
    int          we_cyc = 0;
    always @(negedge clk) begin
        if (!rst) begin
            in_resp = 1'b0;
            we_cnt  = 0;
        end else begin
            if (mem_we) begin
                we_cnt++;
                we_cyc = cyc;
            end
            if (resp_valid) begin
                if (!in_resp) begin
                    in_resp    = 1'b1;
                    first_cyc  = cyc;
                    hold_rdata = resp_rdata;
                    hold_err   = resp_err;
                end else begin
                    chk("hold_rdata", resp_rdata, hold_rdata);
                    chk("hold_err", 32'(resp_err), 32'(hold_err));
                end
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (resp_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_resp", 32'(q.size()), 32'd1);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk({e.name, ".rdata"}, resp_rdata, e.rdata);
                        chk({e.name, ".err"}, 32'(resp_err), 32'(e.err));
                        chk({e.name, ".lat"}, 32'(first_cyc - e.acc), 32'(e.lat));
                        chk({e.name, ".we_cnt"}, 32'(we_cnt), 32'(e.we_cnt));
                        if (e.we_lat >= 0)
                            chk({e.name, ".we_lat"}, 32'(we_cyc - e.acc), 32'(e.we_lat));
                    end
                    in_resp = 1'b0;
                    we_cnt  = 0;
                end
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, record the expectation.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] wd, input logic [31:0] x_rdata,
                         input logic x_err, input int x_lat, input int x_we_cnt,
                         input int x_we_lat, input string nm);
        exp_t e;
        bit   ok;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) begin
            chk({nm, ".accept_timeout"}, 32'd0, 32'd1);
        end else begin
            e.rdata  = x_rdata;
            e.err    = x_err;
            e.lat    = x_lat;
            e.we_cnt = x_we_cnt;
            e.we_lat = x_we_lat;
            e.acc    = cyc;
            e.name   = nm;
            q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            if (q.size() == 0 && !resp_valid) ok = 1'b1;
        end
        if (!ok) chk({nm, ".resp_timeout"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 8'h00;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        rst = 1'b1;

        // Loads from word 0x04 = 0x8899AABB
        issue(1'b0, 3'd0, 8'h05, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, -1, "lb_05");
        issue(1'b0, 3'd4, 8'h07, 32'h0, 32'h00000088, 1'b0, 2, 0, -1, "lbu_07");
        issue(1'b0, 3'd1, 8'h06, 32'h0, 32'hFFFF8899, 1'b0, 2, 0, -1, "lh_06");
        issue(1'b0, 3'd5, 8'h04, 32'h0, 32'h0000AABB, 1'b0, 2, 0, -1, "lhu_04");
        issue(1'b0, 3'd2, 8'h04, 32'h0, 32'h8899AABB, 1'b0, 2, 0, -1, "lw_04");

        // Full-word store then read back
        issue(1'b1, 3'd2, 8'h08, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 1, "sw_08");
        issue(1'b0, 3'd2, 8'h08, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, -1, "lw_08");

        // Sub-word RMW stores on word 0x0C = 0x11223344
        issue(1'b1, 3'd0, 8'h0E, 32'hFFFFFFA5, 32'h0, 1'b0, 3, 1, 2, "sb_0e");
        wait_done("sb_0e");
        chk("mem_0c_after_sb", mem[3], 32'h11A53344);
        issue(1'b1, 3'd1, 8'h0C, 32'h1234BEEF, 32'h0, 1'b0, 3, 1, 2, "sh_0c");
        wait_done("sh_0c");
        chk("mem_0c_after_sh", mem[3], 32'h11A5BEEF);

        // Illegal requests
        issue(1'b0, 3'd2, 8'h02, 32'h0, 32'h0, 1'b1, 1, 0, -1, "lw_02_mis");
        issue(1'b1, 3'd1, 8'h01, 32'h0000CAFE, 32'h0, 1'b1, 1, 0, -1, "sh_01_mis");
        issue(1'b0, 3'd3, 8'h10, 32'h0, 32'h0, 1'b1, 1, 0, -1, "ld_f3_3");
        issue(1'b1, 3'd4, 8'h14, 32'h55555555, 32'h0, 1'b1, 1, 0, -1, "st_f3_4");
        wait_done("errors");
        chk("mem_00_unchanged", mem[0], 32'hC0DE0000);
        chk("mem_10_unchanged", mem[4], 32'hC0DE0004);
        chk("mem_14_unchanged", mem[5], 32'hC0DE0005);

        // Response back-pressure with a pending request behind it
        resp_ready = 1'b0;
        issue(1'b0, 3'd2, 8'h04, 32'h0, 32'h8899AABB, 1'b0, 2, 0, -1, "lw_stall");
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd4;
        req_addr   = 8'h05;
        repeat (7) @(posedge clk);
        #1;
        chk("stall.resp_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        issue(1'b0, 3'd4, 8'h05, 32'h0, 32'h000000AA, 1'b0, 2, 0, -1, "lbu_after_stall");
        wait_done("stall");

        // Reset during the ACCESS cycle of an SB
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 8'h0D;
        req_wdata  = 32'h00000077;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                if (req_ready) ok = 1'b1;
            end
            if (!ok) chk("sb_abort.accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort.mem_we", 32'(mem_we), 32'd0);
        chk("abort.req_ready", 32'(req_ready), 32'd1);
        chk("abort.resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort.mem_0c", mem[3], 32'h11A5BEEF);
        chk("abort.req_ready_after", 32'(req_ready), 32'd1);
        issue(1'b0, 3'd2, 8'h0C, 32'h0, 32'h11A5BEEF, 1'b0, 2, 0, -1, "lw_after_rst");
        wait_done("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Load/store unit that sits between the core's MEM stage and the 1-read/1-write data memory.
- Accepts one byte-addressed load or store per transaction over a valid/ready handshake.
- Drives the memory's word-granular port. Sub-word stores are done as read-modify-write.
- Returns sign- or zero-extended load data, or a store acknowledge, with an error flag for misaligned or illegal requests.

Parameters:
ADDR_W, 8, byte-address width. Must equal the attached memory's address width; the memory drops addr[1:0] internally.
XLEN, 32, data width. Only 32 is supported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when valid & ready
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU
req_addr  input  ADDR_W  byte address
req_wdata  input  XLEN  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  response consumed when valid & ready
resp_rdata  output  XLEN  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal funct3
mem_rd_addr  output  ADDR_W  to memory rd_addr0
mem_wr_addr  output  ADDR_W  to memory wr_addr0
mem_wr_din  output  XLEN  to memory wr_din0
mem_we  output  1  to memory we0
mem_rd_dout  input  XLEN  from memory rd_dout0; combinational read

Behaviour:
Reset values (async, rst=0):
- state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0.
- All latched request registers cleared to 0.

States: IDLE, ACCESS, WRITE, RESP.

IDLE:
- req_ready=1.
- On req_valid, latch we/funct3/addr/wdata.
- Legality check:
  - Illegal: load funct3 in {3,6,7}; store funct3 > 2; H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Illegal request: go to RESP with err=1, rdata=0. Memory is never written.
  - Legal request: go to ACCESS.

ACCESS:
- mem_rd_addr = latched addr.
- Load:
  - Select byte addr[1:0] or half addr[1].
  - Sign-extend for B/H, zero-extend for BU/HU, pass W through.
  - Register into resp_rdata; go to RESP.
- SW: mem_we=1, mem_wr_din = wdata for this cycle; go to RESP.
- SB/SH:
  - Merge wdata[7:0] or wdata[15:0] into mem_rd_dout at the addressed lane.
  - Register the merged word; go to WRITE.

WRITE:
- mem_we=1, mem_wr_din = merged word, mem_wr_addr = latched addr; go to RESP.

RESP:
- resp_valid=1; resp_rdata and resp_err stay stable until resp_ready.
- On resp_ready: go to IDLE and drop resp_valid the next cycle.
- No new request is accepted in the same cycle.

Memory-side and timing rules:
- mem_* outputs are driven only from state and latched registers; there is no combinational path from req_* ports.
- mem_we=0 in IDLE and RESP.
- mem_rd_addr and mem_wr_addr equal the latched addr outside IDLE; in IDLE they hold their last value.
- Latency from accept edge T:
  - Load and SW: resp_valid asserted in cycle T+2. The SW memory write commits at the edge ending T+1.
  - SB/SH: write commits at the edge ending T+2; resp_valid asserted in T+3.
  - Error: resp_valid asserted in T+1.
- Throughput: one transaction outstanding; the minimum back-to-back period is 3 cycles for a load.

Reset mid-operation:
- Return to IDLE immediately; mem_we deasserts asynchronously.
- An RMW aborted before WRITE leaves memory unchanged.

Test Plan:
- Memory word at 0x04 = 0x8899AABB. LB at 0x05 -> resp_rdata=0xFFFFFFAA, err=0. LBU at 0x07 -> 0x00000088. LH at 0x06 -> 0xFFFF8899.
- SW 0xDEADBEEF at 0x08, then LW at 0x08 -> mem_we high for exactly 1 cycle; LW returns 0xDEADBEEF; resp_valid at T+2.
- Word at 0x0C = 0x11223344. SB 0xA5 at 0x0E -> word becomes 0x11A53344. Then SH 0x0BEEF at 0x0C -> word becomes 0x11A5BEEF. mem_we is asserted only in the WRITE cycle.
- LW at 0x02, SH at 0x01, and load funct3=3 -> each gives resp_err=1 and resp_rdata=0 at T+1. mem_we is never asserted, and memory contents are unchanged.
- resp_ready held low for 5 cycles -> resp_valid, resp_rdata and resp_err stay stable. req_ready=0 throughout, and a pending req_valid is not accepted until after the handshake.
- Assert rst low during the ACCESS cycle of an SB -> mem_we=0, state=IDLE, target word unchanged. After rst release, req_ready=1 and a new LW completes normally.
